pipe_ctrl: RTL

Pipeline hazard controller for the 5-stage core. It collects stall and redirect requests from ID, EX and MEM and drives the fetch stage through `jump_stall_inf`. It also drives per-register stall/flush controls for IF/ID, ID/EX and EX/MEM. Redirects that arrive while the front end is held are buffered and issued on the first unstalled cycle.

---
 rtl/ctrl_pkg.sv | 42 ++++
 rtl/jump_stall_inf.sv | 17 +
 rtl/stall_watchdog.sv | 37 +++
 rtl/pipe_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Shared types and widths for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam int COMMON_WIDTH = 32;

    typedef enum logic [0:0] {
        CTRL_RUN  = 1'b0,
        CTRL_PEND = 1'b1
    } ctrl_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE  = 3'd0,
        CAUSE_EXC   = 3'd1,
        CAUSE_MEM   = 3'd2,
        CAUSE_EX    = 3'd3,
        CAUSE_REDIR = 3'd4,
        CAUSE_ID    = 3'd5
    } stall_cause_e;

    // Highest-priority request wins; a redirect masks the ID load-use stall.
    function automatic stall_cause_e pick_cause(
        input logic exc,
        input logic mem,
        input logic ex,
        input logic redir,
        input logic id
    );
        if (exc)        return CAUSE_EXC;
        else if (mem)   return CAUSE_MEM;
        else if (ex)    return CAUSE_EX;
        else if (redir) return CAUSE_REDIR;
        else if (id)    return CAUSE_ID;
        else            return CAUSE_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jump_stall_inf.sv
`default_nettype none
// ============================================================================
// Module   : jump_stall_inf
// Purpose  : Fetch-stage control bundle: stall request and redirect target.
// Revision : 1.0 - initial release
// ============================================================================
interface jump_stall_inf;
    import ctrl_pkg::*;

    logic                    stall;
    logic                    jump_en;
    logic [COMMON_WIDTH-1:0] jump_addr;

    modport ctrl  (output stall, jump_en, jump_addr);
    modport fetch (input  stall, jump_en, jump_addr);
endinterface
`default_nettype wire

// File: rtl/stall_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : stall_watchdog
// Purpose  : Counts consecutive stalled cycles; sticky timeout at LIMIT.
// Revision : 1.0 - initial release
// ============================================================================
module stall_watchdog #(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic timeout
);
    localparam int              c_CW    = $clog2(LIMIT + 1);
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(LIMIT);

    logic [c_CW-1:0] r_count;
    logic            r_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_count == c_LIMIT)
                r_timeout <= 1'b1;
            if (!stall)
                r_count <= '0;
            else if (r_count != c_LIMIT)
                r_count <= r_count + 1'b1;
        end
    end

    assign timeout = r_timeout;
endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : 5-stage pipeline hazard controller (stall/flush/redirect).
//            Optional perf counters when PIPE_CTRL_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import ctrl_pkg::*;
#(
    parameter int STALL_LIMIT = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    jump_stall_inf.ctrl             jump_stall,
    input  logic                    id_stall_req,
    input  logic                    ex_busy,
    input  logic                    mem_wait,
    input  logic                    ex_redirect_en,
    input  logic [COMMON_WIDTH-1:0] ex_redirect_addr,
    input  logic                    exc_en,
    input  logic [COMMON_WIDTH-1:0] exc_vector,
    output logic                    stall_ifid,
    output logic                    stall_idex,
    output logic                    stall_exmem,
    output logic                    flush_ifid,
    output logic                    flush_idex,
    output logic                    flush_exmem,
`ifdef PIPE_CTRL_PERF_EN
    output logic                    stall_timeout,
    output logic [31:0]             perf_stall_cycles,
    output logic [31:0]             perf_redirects
`else
    output logic                    stall_timeout
`endif
);
    localparam logic [0:0] c_ST_RUN  = CTRL_RUN;
    localparam logic [0:0] c_ST_PEND = CTRL_PEND;

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic [COMMON_WIDTH-1:0] r_pend_addr;
    logic [COMMON_WIDTH-1:0] w_pend_addr_nxt;

    stall_cause_e            w_cause;
    logic                    w_stall;
    logic                    w_jump_en;
    logic [COMMON_WIDTH-1:0] w_jump_addr;
    logic                    w_timeout;

    assign w_cause = pick_cause(exc_en, mem_wait, ex_busy,
                                ex_redirect_en | (r_state == c_ST_PEND),
                                id_stall_req);

    // Everything is forced low while reset is held.
    always_comb begin
        w_stall     = 1'b0;
        w_jump_en   = 1'b0;
        w_jump_addr = '0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        stall_exmem = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        if (!rst) begin
            case (w_cause)
                CAUSE_EXC: begin
                    w_jump_en   = 1'b1;
                    w_jump_addr = exc_vector;
                    flush_ifid  = 1'b1;
                    flush_idex  = 1'b1;
                    flush_exmem = 1'b1;
                end
                CAUSE_MEM: begin
                    w_stall     = 1'b1;
                    stall_ifid  = 1'b1;
                    stall_idex  = 1'b1;
                    stall_exmem = 1'b1;
                end
                CAUSE_EX: begin
                    w_stall     = 1'b1;
                    stall_ifid  = 1'b1;
                    stall_idex  = 1'b1;
                    flush_exmem = 1'b1;
                end
                CAUSE_REDIR: begin
                    w_jump_en   = 1'b1;
                    w_jump_addr = ex_redirect_en ? ex_redirect_addr : r_pend_addr;
                    flush_ifid  = 1'b1;
                    flush_idex  = 1'b1;
                end
                CAUSE_ID: begin
                    w_stall     = 1'b1;
                    stall_ifid  = 1'b1;
                    flush_idex  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A redirect seen under a back-end stall is parked until the stall clears.
    always_comb begin
        w_state_nxt     = r_state;
        w_pend_addr_nxt = r_pend_addr;
        if (exc_en) begin
            w_state_nxt = c_ST_RUN;
        end else if (mem_wait | ex_busy) begin
            if (ex_redirect_en) begin
                w_state_nxt     = c_ST_PEND;
                w_pend_addr_nxt = ex_redirect_addr;
            end
        end else begin
            w_state_nxt = c_ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_RUN;
            r_pend_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend_addr <= w_pend_addr_nxt;
        end
    end

    stall_watchdog #(
        .LIMIT   (STALL_LIMIT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .stall   (w_stall),
        .timeout (w_timeout)
    );

    assign jump_stall.stall     = w_stall;
    assign jump_stall.jump_en   = w_jump_en;
    assign jump_stall.jump_addr = w_jump_addr;
    assign stall_timeout        = w_timeout & ~rst;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_redir;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_redir <= '0;
        end else begin
            if (w_stall)
                r_perf_stall <= r_perf_stall + 32'd1;
            if (w_jump_en)
                r_perf_redir <= r_perf_redir + 32'd1;
        end
    end

    assign perf_stall_cycles = rst ? 32'd0 : r_perf_stall;
    assign perf_redirects    = rst ? 32'd0 : r_perf_redir;
`endif
endmodule
`default_nettype wire
